// File: rtl/sram_port_arbiter_pkg.sv
// Shared c0 SRAM definitions: macro geometry (32x512, byte masks) and the
// in-flight tag record that travels alongside each SRAM access.
package sram_port_arbiter_pkg;

  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_MASK_W = 4;
  localparam int SRAM_ADDR_W = 9;

  typedef struct packed {
    logic valid;
    logic port;
    logic we;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, port: 1'b0, we: 1'b0};

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer names the port that wins a tie and
// moves to the other port whenever a grant is issued.
module rr_arbiter2 (
  input  logic       clk_g,
  input  logic       rst_g,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_port
);

  logic r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      if (r_ptr) begin
        o_gnt = 2'b10;
      end else begin
        o_gnt = 2'b01;
      end
    end else begin
      o_gnt = i_req;
    end
  end

  assign o_port = o_gnt[1];

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      r_ptr <= 1'b0;
    end else if (|o_gnt) begin
      r_ptr <= ~o_gnt[1];
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester front end for a single-port SRAM macro: round-robin accept,
// registered SRAM drive, fixed three-cycle in-order response per acceptance.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_BIT = SRAM_ADDR_W
) (
  input  logic                   clk_g,
  input  logic                   rst_g,
  input  logic                   rq0_valid,
  output logic                   rq0_ready,
  input  logic                   rq0_we,
  input  logic [SRAM_MASK_W-1:0] rq0_wmask,
  input  logic [ADDR_BIT-1:0]    rq0_addr,
  input  logic [SRAM_DATA_W-1:0] rq0_wdata,
  input  logic                   rq1_valid,
  output logic                   rq1_ready,
  input  logic                   rq1_we,
  input  logic [SRAM_MASK_W-1:0] rq1_wmask,
  input  logic [ADDR_BIT-1:0]    rq1_addr,
  input  logic [SRAM_DATA_W-1:0] rq1_wdata,
  output logic                   rs0_valid,
  output logic [SRAM_DATA_W-1:0] rs0_rdata,
  output logic                   rs1_valid,
  output logic [SRAM_DATA_W-1:0] rs1_rdata,
  output logic                   sram_csb0,
  output logic                   sram_web0,
  output logic [SRAM_MASK_W-1:0] sram_wmask0,
  output logic [ADDR_BIT-1:0]    sram_addr0,
  output logic [SRAM_DATA_W-1:0] sram_din0,
  input  logic [SRAM_DATA_W-1:0] sram_dout0
);

  logic [1:0]             w_gnt;
  logic                   w_port;
  logic                   w_acc;
  logic                   w_we;
  logic [SRAM_MASK_W-1:0] w_wmask;
  logic [ADDR_BIT-1:0]    w_addr;
  logic [SRAM_DATA_W-1:0] w_wdata;

  logic                   r_csb;
  logic                   r_web;
  logic [SRAM_MASK_W-1:0] r_wmask;
  logic [ADDR_BIT-1:0]    r_addr;
  logic [SRAM_DATA_W-1:0] r_din;
  tag_t                   r_tag1;
  tag_t                   r_tag2;
  logic                   r_rs0_valid;
  logic                   r_rs1_valid;
  logic [SRAM_DATA_W-1:0] r_rs0_rdata;
  logic [SRAM_DATA_W-1:0] r_rs1_rdata;

  rr_arbiter2 u_arb (
    .clk_g  (clk_g),
    .rst_g  (rst_g),
    .i_req  ({rq1_valid, rq0_valid}),
    .o_gnt  (w_gnt),
    .o_port (w_port)
  );

  assign rq0_ready = w_gnt[0];
  assign rq1_ready = w_gnt[1];
  assign w_acc     = |w_gnt;

  assign w_we    = w_port ? rq1_we    : rq0_we;
  assign w_wmask = w_port ? rq1_wmask : rq0_wmask;
  assign w_addr  = w_port ? rq1_addr  : rq0_addr;
  assign w_wdata = w_port ? rq1_wdata : rq0_wdata;

  // Idle drive values are all-zero with csb/web high so the macro sees no access.
  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= {SRAM_MASK_W{1'b0}};
      r_addr  <= {ADDR_BIT{1'b0}};
      r_din   <= {SRAM_DATA_W{1'b0}};
      r_tag1  <= TAG_IDLE;
      r_tag2  <= TAG_IDLE;
    end else begin
      if (w_acc) begin
        r_csb   <= 1'b0;
        r_web   <= ~w_we;
        r_wmask <= w_wmask;
        r_addr  <= w_addr;
        r_din   <= w_wdata;
        r_tag1  <= '{valid: 1'b1, port: w_port, we: w_we};
      end else begin
        r_csb   <= 1'b1;
        r_web   <= 1'b1;
        r_wmask <= {SRAM_MASK_W{1'b0}};
        r_addr  <= {ADDR_BIT{1'b0}};
        r_din   <= {SRAM_DATA_W{1'b0}};
        r_tag1  <= TAG_IDLE;
      end
      r_tag2 <= r_tag1;
    end
  end

  // Read data is valid one cycle after the macro samples, i.e. while r_tag2 is live.
  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      r_rs0_valid <= 1'b0;
      r_rs1_valid <= 1'b0;
      r_rs0_rdata <= {SRAM_DATA_W{1'b0}};
      r_rs1_rdata <= {SRAM_DATA_W{1'b0}};
    end else begin
      r_rs0_valid <= r_tag2.valid & ~r_tag2.port;
      r_rs1_valid <= r_tag2.valid &  r_tag2.port;
      if (r_tag2.valid && !r_tag2.port) begin
        r_rs0_rdata <= r_tag2.we ? {SRAM_DATA_W{1'b0}} : sram_dout0;
      end else begin
        r_rs0_rdata <= r_rs0_rdata;
      end
      if (r_tag2.valid && r_tag2.port) begin
        r_rs1_rdata <= r_tag2.we ? {SRAM_DATA_W{1'b0}} : sram_dout0;
      end else begin
        r_rs1_rdata <= r_rs1_rdata;
      end
    end
  end

  assign sram_csb0   = r_csb;
  assign sram_web0   = r_web;
  assign sram_wmask0 = r_wmask;
  assign sram_addr0  = r_addr;
  assign sram_din0   = r_din;
  assign rs0_valid   = r_rs0_valid;
  assign rs1_valid   = r_rs1_valid;
  assign rs0_rdata   = r_rs0_rdata;
  assign rs1_rdata   = r_rs1_rdata;

endmodule
